// File: rtl/birdwtch_axil_pkg.sv
// Shared constants and state encodings for the birdwtch AXI4-Lite register slave.
package birdwtch_axil_pkg;

  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [IDX_W-1:0] REG_IDX_0 = 2'd0;
  localparam logic [IDX_W-1:0] REG_IDX_1 = 2'd1;
  localparam logic [IDX_W-1:0] REG_IDX_2 = 2'd2;
  localparam logic [IDX_W-1:0] REG_IDX_3 = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/birdwtch_axil_wchan.sv
// Write-channel FSM: joins AW and W in either order, emits a one-cycle commit and holds B.
// Commit is combinational on the final handshake edge so the register array updates that same edge.
module birdwtch_axil_wchan
  import birdwtch_axil_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic                wr_en_o,
  output logic [ADDR_W-3:0]   wr_idx_o,
  output logic [DATA_W-1:0]   wr_data_o,
  output logic [DATA_W/8-1:0] wr_strb_o
);

  w_state_e              state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [ADDR_W-3:0]     idx_q;
  logic [DATA_W-1:0]     data_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic                  aw_hs, w_hs;
  logic                  unused_addr_lsb;

  assign aw_hs           = awvalid_i & awready_q;
  assign w_hs            = wvalid_i & wready_q;
  assign unused_addr_lsb = ^awaddr_i[1:0];

  assign wr_en_o   = (state_q == W_IDLE      && aw_hs && w_hs) ||
                     (state_q == W_HAVE_ADDR && w_hs) ||
                     (state_q == W_HAVE_DATA && aw_hs);
  assign wr_idx_o  = (state_q == W_HAVE_ADDR) ? idx_q  : awaddr_i[ADDR_W-1:2];
  assign wr_data_o = (state_q == W_HAVE_DATA) ? data_q : wdata_i;
  assign wr_strb_o = (state_q == W_HAVE_DATA) ? strb_q : wstrb_i;

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = RESP_OKAY;

  // Readies are registered and stay low through reset, rising on the first edge after it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            state_q   <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
          end else if (aw_hs) begin
            state_q   <= W_HAVE_ADDR;
            idx_q     <= awaddr_i[ADDR_W-1:2];
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            state_q   <= W_HAVE_DATA;
            data_q    <= wdata_i;
            strb_q    <= wstrb_i;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_HAVE_ADDR: begin
          if (w_hs) begin
            state_q  <= W_RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
          end
        end
        W_HAVE_DATA: begin
          if (aw_hs) begin
            state_q   <= W_RESP;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            state_q   <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/birdwtch_axil_regs.sv
// AXI4-Lite slave with NUM_REGS 32-bit registers, byte-strobed writes and per-register write pulses.
// Read path and register array live here; the write handshake logic is in birdwtch_axil_wchan.
module birdwtch_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                    wr_pulse
);
  import birdwtch_axil_pkg::*;

  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int REG_IDX_W = C_S_AXI_ADDR_WIDTH - 2;

  logic                 wr_en;
  logic [REG_IDX_W-1:0] wr_idx;
  logic [DW-1:0]        wr_data;
  logic [DW/8-1:0]      wr_strb;
  logic [DW-1:0]        regs_q [NUM_REGS];
  logic [DW-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]  wr_pulse_q;
  r_state_e             rstate_q;
  logic                 arready_q, rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic                 ar_hs;
  logic                 unused_rd_bits;

  birdwtch_axil_wchan #(
    .ADDR_W (C_S_AXI_ADDR_WIDTH),
    .DATA_W (DW)
  ) u_wchan (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .awaddr_i  (S_AXI_AWADDR),
    .awvalid_i (S_AXI_AWVALID),
    .awready_o (S_AXI_AWREADY),
    .wdata_i   (S_AXI_WDATA),
    .wstrb_i   (S_AXI_WSTRB),
    .wvalid_i  (S_AXI_WVALID),
    .wready_o  (S_AXI_WREADY),
    .bresp_o   (S_AXI_BRESP),
    .bvalid_o  (S_AXI_BVALID),
    .bready_i  (S_AXI_BREADY),
    .wr_en_o   (wr_en),
    .wr_idx_o  (wr_idx),
    .wr_data_o (wr_data),
    .wr_strb_o (wr_strb)
  );

  assign unused_rd_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0]};

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      for (int b = 0; b < DW/8; b++) begin
        if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs_q     <= '{default: '0};
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_en ? (NUM_REGS'(1) << wr_idx) : '0;
    end
  end

  assign ar_hs = S_AXI_ARVALID & arready_q;

  // Capture reads from regs_q so a same-edge write commit is not visible yet.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rstate_q  <= R_RESP;
            rdata_q   <= regs_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (S_AXI_RREADY) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign wr_pulse      = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_q[DW*i +: DW] = regs_q[i];
  end

endmodule

// File: tb/tb_birdwtch_axil_regs.sv
// Scoreboard bench for birdwtch_axil_regs: stimulus pushes expected B/R responses, a monitor pops on handshakes.
module tb_birdwtch_axil_regs;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0]  exp_b[$];
  logic [31:0] exp_r[$];
  int pulse_cnt[4];

  birdwtch_axil_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .NUM_REGS           (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .wr_pulse      (wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESET) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (exp_b.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL b_unexpected: got BRESP %h with no write outstanding", S_AXI_BRESP);
          end else check("bresp", S_AXI_BRESP, exp_b.pop_front());
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (exp_r.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL r_unexpected: got RDATA %h with no read outstanding", S_AXI_RDATA);
          end else begin
            check("rdata", S_AXI_RDATA, exp_r.pop_front());
            check("rresp", S_AXI_RRESP, 2'b00);
          end
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int i = 0; i < 4; i++) pulse_cnt[i] += int'(wr_pulse[i]);
    end
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit aw_ok = 1'b0;
    bit w_ok  = 1'b0;
    int n = 0;
    exp_b.push_back(2'b00);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    while (!(aw_ok && w_ok) && n < 50) begin
      @(negedge ACLK);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_ok = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_ok = 1'b1;
      tick();
      n++;
      if (aw_ok) S_AXI_AWVALID = 1'b0;
      if (w_ok)  S_AXI_WVALID  = 1'b0;
    end
    if (!(aw_ok && w_ok)) begin
      n_cmp++; n_err++;
      $display("FAIL write_accept_timeout: aw=%0d w=%0d required both 1", aw_ok, w_ok);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    bit ok = 1'b0;
    int n = 0;
    exp_r.push_back(exp);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!ok && n < 50) begin
      @(negedge ACLK);
      if (S_AXI_ARVALID && S_AXI_ARREADY) ok = 1'b1;
      tick();
      n++;
      if (ok) S_AXI_ARVALID = 1'b0;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL read_accept_timeout: ar accepted=0 required 1");
      S_AXI_ARVALID = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    if (exp_b.size() != 0 || exp_r.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL response_timeout: pending b=%0d r=%0d required 0", exp_b.size(), exp_r.size());
      exp_b.delete(); exp_r.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

    repeat (3) @(posedge ACLK);
    #1;
    check("rst_handshake_outs",
          {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, wr_pulse}, '0);
    check("rst_reg_q", reg_q, '0);
    check("rst_rdata", S_AXI_RDATA, '0);
    ARESET = 1'b0;
    #3;
    check("ready_before_first_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    tick();
    check("ready_after_first_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Four full-word writes with AW and W together, then read back.
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(i * 4), 32'(i + 1), 4'hF);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 32'(i + 1));
      wait_idle();
    end
    check("seq_reg_q", reg_q, {32'h4, 32'h3, 32'h2, 32'h1});
    for (int i = 0; i < 4; i++) check($sformatf("pulse_count_%0d", i), pulse_cnt[i], 1);

    // Byte strobes: only bytes 0 and 2 take the new value.
    axi_write(4'h4, 32'hAABBCCDD, 4'hF);
    wait_idle();
    axi_write(4'h4, 32'h11223344, 4'b0101);
    wait_idle();
    check("strobe_reg1", reg_q[63:32], 32'hAA22CC44);
    axi_read(4'h4, 32'hAA22CC44);
    wait_idle();

    // AW first, W three cycles later.
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    tick();
    check("aw_first_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b010);
    S_AXI_AWVALID = 1'b0;
    tick(); tick();
    check("aw_first_no_commit", reg_q[127:96], 32'h4);
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    check("aw_first_commit", {S_AXI_BVALID, wr_pulse}, {1'b1, 4'b1000});
    check("aw_first_reg3", reg_q[127:96], 32'h77);
    S_AXI_WVALID = 1'b0;
    wait_idle();

    // W first, AW three cycles later.
    S_AXI_WDATA = 32'h88; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    check("w_first_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
    S_AXI_WVALID = 1'b0;
    tick(); tick();
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    check("w_first_commit", {S_AXI_BVALID, wr_pulse}, {1'b1, 4'b0010});
    check("w_first_reg1", reg_q[63:32], 32'h88);
    S_AXI_AWVALID = 1'b0;
    wait_idle();

    // BREADY held low: response held, second write stalls.
    S_AXI_BREADY = 1'b0;
    axi_write(4'h0, 32'h55, 4'hF);
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h66; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bstall_cycle%0d", k), {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP}, 5'b10000);
    end
    check("bstall_reg2_held", reg_q[95:64], 32'h3);
    S_AXI_BREADY = 1'b1;
    axi_write(4'h8, 32'h66, 4'hF);
    wait_idle();
    check("bstall_reg0", reg_q[31:0], 32'h55);
    check("bstall_reg2", reg_q[95:64], 32'h66);

    // Same-edge read and write to reg2: read sees the old value.
    axi_write(4'h8, 32'h5, 4'hF);
    wait_idle();
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h9; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    exp_r.push_back(32'h5);
    exp_b.push_back(2'b00);
    tick();
    S_AXI_ARVALID = 1'b0; S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("same_edge_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    check("same_edge_reg2", reg_q[95:64], 32'h9);
    wait_idle();
    axi_read(4'h8, 32'h9);
    wait_idle();

    // Reset while a write response is pending.
    S_AXI_BREADY = 1'b0;
    axi_write(4'h0, 32'h1234, 4'hF);
    check("pre_reset_state", {S_AXI_BVALID, reg_q[31:0]}, {1'b1, 32'h1234});
    #2;
    ARESET = 1'b1;
    #1;
    check("mid_reset_outs", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_RVALID, wr_pulse}, '0);
    check("mid_reset_reg_q", reg_q, '0);
    exp_b.delete();
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
    check("post_reset_state", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 4'b0111);
    tick();
    axi_write(4'h4, 32'hCAFE, 4'hF);
    wait_idle();
    axi_read(4'h4, 32'hCAFE);
    wait_idle();
    axi_read(4'h0, 32'h0);
    wait_idle();
    check("post_reset_reg_q", reg_q, {32'h0, 32'h0, 32'hCAFE, 32'h0});

    tick(); tick();
    check("queues_drained", exp_b.size() + exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/birdwtch_axil_regs.md
# birdwtch_axil_regs

AXI4-Lite slave register file sitting directly downstream of the S00_AXI master port of the birdwtch interface. It terminates the master's write and read transactions and holds four 32-bit control/status registers. Register contents and per-register write strobes are presented as outputs to the birdwatch datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = addr[3:2].
- NUM_REGS, 4, register count; must equal 2**(C_S_AXI_ADDR_WIDTH-2).
- ACLK  in  1  single clock; all state on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID  in  4 / 3 / 1  write address channel; AWPROT ignored.
- S_AXI_AWREADY  out  1  write address accept.
- S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID  in  32 / 4 / 1  write data channel.
- S_AXI_WREADY  out  1  write data accept.
- S_AXI_BRESP / S_AXI_BVALID  out  2 / 1  write response.
- S_AXI_BREADY  in  1  response accept.
- S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID  in  4 / 3 / 1  read address; ARPROT ignored.
- S_AXI_ARREADY  out  1  read address accept.
- S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID  out  32 / 2 / 1  read data.
- S_AXI_RREADY  in  1  read data accept.
- reg_q  out  NUM_REGS*32  register contents, reg i at [32i+31:32i].
- wr_pulse  out  NUM_REGS  one-cycle pulse per register on write commit.

## Operation
- Reset (ARESET high, asynchronous): all registers 0; all READY/VALID outputs 0; BRESP/RRESP/RDATA 0; wr_pulse 0; FSMs to idle; any in-flight transaction dropped.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - W_IDLE: AWREADY=WREADY=1. Both handshakes same cycle -> commit, go W_RESP. AW only -> latch addr, W_HAVE_ADDR. W only -> latch data/strobe, W_HAVE_DATA.
  - W_HAVE_ADDR: AWREADY=0, WREADY=1; W handshake -> commit, W_RESP. W_HAVE_DATA symmetric.
  - W_RESP: AWREADY=WREADY=0, BVALID=1, BRESP=OKAY(2'b00); BVALID and BRESP held stable until BREADY; on BVALID&&BREADY -> W_IDLE.
  - Commit: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] <= WDATA[8b+7:8b]; other bytes unchanged. wr_pulse[idx]=1 for exactly one cycle, even if WSTRB=0.
- Read FSM states: R_IDLE (ARREADY=1), R_RESP (ARREADY=0, RVALID=1, RRESP=OKAY). AR handshake captures RDATA=reg[ARADDR[3:2]]; RDATA held stable until RVALID&&RREADY, then R_IDLE.
- Read and write channels are fully independent; both may be active simultaneously.
- addr[1:0] ignored; every address decodes; no SLVERR.

## Timing
- Readies are registered: first rise in the cycle after ARESET deasserts.
- Write latency: final AW/W handshake at edge N -> reg_q updated, BVALID=1 and wr_pulse=1 from edge N; wr_pulse low again after edge N+1.
- Read latency: AR handshake at edge N -> RVALID=1 from edge N with data.
- Back-to-back: after B or R handshake at edge N, READY is high from edge N; the next handshake completes no earlier than edge N+1.
- Same-edge AR handshake and write commit to the same register: RDATA returns the pre-write value.
- BREADY/RREADY held low indefinitely: FSM waits, no timeout.
- ARESET asserted mid-transaction: VALIDs drop asynchronously; the pending response is never issued.

## Structure
- Package birdwtch_axil_pkg: RESP_OKAY constant, write/read state enums, NUM_REGS, register index constants.
- One sub-module natural: birdwtch_axil_wchan (write FSM, address/data latching, B channel); read path and register array stay in the top.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC (AW+W same cycle), read back in order -> RDATA 0x1..0x4, all BRESP/RRESP=OKAY; wr_pulse bits 0..3 each pulse once.
- Reg1=0xAABBCCDD, then write 0x11223344 with WSTRB=4'b0101 -> reg_q[63:32]=0xAA22CC44.
- AW at cycle 0, W delayed 3 cycles; then W first, AW 3 cycles later -> AWREADY low while address held; BVALID the edge after the second handshake; data lands in the correct register.
- BREADY held low 5 cycles after write -> BVALID stays 1, AWREADY/WREADY stay 0, second write stalls until B handshake.
- Reg2=0x5; same-edge AR to 0x8 and write 0x9 to 0x8 -> RDATA=0x5, then read -> 0x9.
- ARESET pulsed while BVALID=1 and reg0=0x1234 -> BVALID=0, reg_q all 0, no B handshake; next write/read pair works normally.
